// File: rtl/xvc_stream_initiator.sv
// xvc_stream_initiator
// Initiator for a single-beat AXI-Stream request/response exchange. Each
// command word is sent as a one-beat packet. The reply beat is checked against
// the request doubled (mod 2^DATA_WIDTH). The result is reported as a one-cycle
// record, and saturating pass/fail counters are kept.

module xvc_stream_initiator #(
    parameter int unsigned DATA_WIDTH     = 512,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      i_clk,
    input  logic                      i_reset,

    input  logic                      i_cmd_valid,
    output logic                      o_cmd_ready,
    input  logic [DATA_WIDTH-1:0]     i_cmd_data,
    input  logic [DATA_WIDTH/8-1:0]   i_cmd_keep,

    output logic                      o_output_TVALID,
    input  logic                      i_output_TREADY,
    output logic [DATA_WIDTH-1:0]     o_output_TDATA,
    output logic [DATA_WIDTH/8-1:0]   o_output_TKEEP,
    output logic                      o_output_TLAST,

    input  logic                      i_input_TVALID,
    output logic                      o_input_TREADY,
    input  logic [DATA_WIDTH-1:0]     i_input_TDATA,
    input  logic [DATA_WIDTH/8-1:0]   i_input_TKEEP,
    input  logic                      i_input_TLAST,

    output logic                      o_rsp_valid,
    output logic [DATA_WIDTH-1:0]     o_rsp_data,
    output logic [DATA_WIDTH/8-1:0]   o_rsp_keep,
    output logic                      o_rsp_match,
    output logic                      o_rsp_timeout,
    output logic [15:0]               o_pass_count,
    output logic [15:0]               o_fail_count
);

    localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH  = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_DRAIN,
        ST_DONE
    } state_e;

    state_e                  state_q;
    logic                    cmd_ready_q;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic [KEEP_WIDTH-1:0]   out_keep_q;
    logic                    in_ready_q;
    logic [DATA_WIDTH-1:0]   expected_q;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic [DATA_WIDTH-1:0]   cap_data_q;
    logic [KEEP_WIDTH-1:0]   cap_keep_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q;
    logic [KEEP_WIDTH-1:0]   rsp_keep_q;
    logic                    rsp_match_q;
    logic                    rsp_timeout_q;
    logic [15:0]             pass_q;
    logic [15:0]             fail_q;

    logic [DATA_WIDTH-1:0]   expected_d;
    logic                    beat_match_d;
    logic [15:0]             pass_inc_d;
    logic [15:0]             fail_inc_d;

    // Doubling drops the request MSB, so the expected value wraps mod 2^DATA_WIDTH.
    assign expected_d   = {i_cmd_data[DATA_WIDTH-2:0], 1'b0};
    assign beat_match_d = (i_input_TDATA == expected_q);
    assign pass_inc_d   = (pass_q == 16'hFFFF) ? pass_q : pass_q + 16'd1;
    assign fail_inc_d   = (fail_q == 16'hFFFF) ? fail_q : fail_q + 16'd1;

    // Exchange controller: every output is a flop updated here.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b1;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_keep_q    <= '0;
            in_ready_q    <= 1'b0;
            expected_q    <= '0;
            cnt_q         <= '0;
            cap_data_q    <= '0;
            cap_keep_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_keep_q    <= '0;
            rsp_match_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            pass_q        <= '0;
            fail_q        <= '0;
        end else begin
            // NOTE: state is updated with <= so every branch reads the values
            // from before this edge. The pulse default below is safe only
            // because a later assignment in the same block overrides it.
            rsp_valid_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        out_data_q  <= i_cmd_data;
                        out_keep_q  <= i_cmd_keep;
                        expected_q  <= expected_d;
                        cmd_ready_q <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (i_output_TREADY) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    // A beat in the final WAIT cycle wins over the timeout.
                    if (i_input_TVALID) begin
                        if (i_input_TLAST) begin
                            rsp_data_q    <= i_input_TDATA;
                            rsp_keep_q    <= i_input_TKEEP;
                            rsp_match_q   <= beat_match_d;
                            rsp_timeout_q <= 1'b0;
                            rsp_valid_q   <= 1'b1;
                            in_ready_q    <= 1'b0;
                            if (beat_match_d) begin
                                pass_q <= pass_inc_d;
                            end else begin
                                fail_q <= fail_inc_d;
                            end
                            state_q <= ST_DONE;
                        end else begin
                            // A multi-beat reply never matches. Keep the first
                            // beat for the record and discard the rest.
                            cap_data_q <= i_input_TDATA;
                            cap_keep_q <= i_input_TKEEP;
                            state_q    <= ST_DRAIN;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        rsp_data_q    <= '0;
                        rsp_keep_q    <= '0;
                        rsp_match_q   <= 1'b0;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        in_ready_q    <= 1'b0;
                        fail_q        <= fail_inc_d;
                        state_q       <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_DRAIN: begin
                    if (i_input_TVALID && i_input_TLAST) begin
                        rsp_data_q    <= cap_data_q;
                        rsp_keep_q    <= cap_keep_q;
                        rsp_match_q   <= 1'b0;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        in_ready_q    <= 1'b0;
                        fail_q        <= fail_inc_d;
                        state_q       <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready     = cmd_ready_q;
    assign o_output_TVALID = out_valid_q;
    assign o_output_TDATA  = out_data_q;
    assign o_output_TKEEP  = out_keep_q;
    assign o_output_TLAST  = out_valid_q;
    assign o_input_TREADY  = in_ready_q;
    assign o_rsp_valid     = rsp_valid_q;
    assign o_rsp_data      = rsp_data_q;
    assign o_rsp_keep      = rsp_keep_q;
    assign o_rsp_match     = rsp_match_q;
    assign o_rsp_timeout   = rsp_timeout_q;
    assign o_pass_count    = pass_q;
    assign o_fail_count    = fail_q;

endmodule

// File: tb/tb_xvc_stream_initiator.sv
// tb_xvc_stream_initiator
// Self-checking bench. It acts as the command source and as the far-end stream
// responder. Expected records come from a reference model: the reply must be a
// single beat equal to the request doubled mod 2^512. Pass and fail are tallied
// as plain integers.

module tb_xvc_stream_initiator;

    localparam int DW  = 512;
    localparam int KW  = DW / 8;
    localparam int TMO = 8;

    logic            clk;
    logic            reset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [DW-1:0]   cmd_data;
    logic [KW-1:0]   cmd_keep;
    logic            out_tvalid;
    logic            out_tready;
    logic [DW-1:0]   out_tdata;
    logic [KW-1:0]   out_tkeep;
    logic            out_tlast;
    logic            in_tvalid;
    logic            in_tready;
    logic [DW-1:0]   in_tdata;
    logic [KW-1:0]   in_tkeep;
    logic            in_tlast;
    logic            rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic [KW-1:0]   rsp_keep;
    logic            rsp_match;
    logic            rsp_timeout;
    logic [15:0]     pass_count;
    logic [15:0]     fail_count;

    int checks   = 0;
    int errors   = 0;
    int pass_exp = 0;
    int fail_exp = 0;
    int cyc      = 0;

    logic [DW-1:0] beat_data [4];
    logic [KW-1:0] beat_keep [4];

    xvc_stream_initiator #(
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_cmd_valid     (cmd_valid),
        .o_cmd_ready     (cmd_ready),
        .i_cmd_data      (cmd_data),
        .i_cmd_keep      (cmd_keep),
        .o_output_TVALID (out_tvalid),
        .i_output_TREADY (out_tready),
        .o_output_TDATA  (out_tdata),
        .o_output_TKEEP  (out_tkeep),
        .o_output_TLAST  (out_tlast),
        .i_input_TVALID  (in_tvalid),
        .o_input_TREADY  (in_tready),
        .i_input_TDATA   (in_tdata),
        .i_input_TKEEP   (in_tkeep),
        .i_input_TLAST   (in_tlast),
        .o_rsp_valid     (rsp_valid),
        .o_rsp_data      (rsp_data),
        .o_rsp_keep      (rsp_keep),
        .o_rsp_match     (rsp_match),
        .o_rsp_timeout   (rsp_timeout),
        .o_pass_count    (pass_count),
        .o_fail_count    (fail_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] model_double(input logic [DW-1:0] r);
        return r + r;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    // Present a command once ready is seen; returns at the negedge after acceptance.
    task automatic issue_cmd(input logic [DW-1:0] d, input logic [KW-1:0] k, output int acc_cyc);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin tick(); n++; end
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready_wait got %b want 1", cmd_ready); end
        acc_cyc   = cyc;
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_keep  = k;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic handshake(input int stall);
        repeat (stall) tick();
        out_tready = 1'b1;
        tick();
        out_tready = 1'b0;
    endtask

    // Drive beats 0..n-1 from beat_data/beat_keep. TLAST goes on the final beat.
    task automatic send_beats(input int n, output int taken);
        int guard;
        taken = 0;
        for (int b = 0; b < n; b++) begin
            in_tvalid = 1'b1;
            in_tdata  = beat_data[b];
            in_tkeep  = beat_keep[b];
            in_tlast  = (b == n - 1);
            guard = 0;
            while (in_tready !== 1'b1 && guard < 50) begin tick(); guard++; end
            if (in_tready === 1'b1) taken++;
            tick();
        end
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
    endtask

    task automatic wait_rsp(output int waited);
        waited = 0;
        while (rsp_valid !== 1'b1 && waited < 40) begin tick(); waited++; end
    endtask

    task automatic drive_exchange(input logic [DW-1:0] req, input logic [KW-1:0] keep,
                                  input int stall, input int delay, input int nbeats,
                                  output int taken, output int waited);
        int acc;
        issue_cmd(req, keep, acc);
        handshake(stall);
        repeat (delay) tick();
        send_beats(nbeats, taken);
        wait_rsp(waited);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        checks++; if (out_tvalid !== 1'b0 || out_tlast !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b/%b want 0/0", out_tvalid, out_tlast); end
        checks++; if (in_tready !== 1'b0) begin errors++; $display("FAIL reset_in_tready got %b want 0", in_tready); end
        checks++; if (rsp_valid !== 1'b0 || rsp_match !== 1'b0 || rsp_timeout !== 1'b0) begin errors++; $display("FAIL reset_rsp_flags got %b%b%b want 000", rsp_valid, rsp_match, rsp_timeout); end
        checks++; if (rsp_data !== '0 || out_tdata !== '0) begin errors++; $display("FAIL reset_data got nonzero want 0"); end
        checks++; if (pass_count !== 16'd0 || fail_count !== 16'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", pass_count, fail_count); end
    endtask

    task automatic test_basic_pass();
        logic [DW-1:0] req, exp_d;
        logic [KW-1:0] keep;
        int acc, taken;
        req = '0;
        req[511:504] = 8'h02;
        req[231:200] = 32'h863787d9;
        keep  = 64'h8000000000000000;
        exp_d = model_double(req);
        issue_cmd(req, keep, acc);
        checks++; if (out_tvalid !== 1'b1 || out_tlast !== 1'b1) begin errors++; $display("FAIL basic_tvalid got %b/%b want 1/1", out_tvalid, out_tlast); end
        checks++; if (out_tdata !== req) begin errors++; $display("FAIL basic_tdata got %h want %h", out_tdata, req); end
        checks++; if (out_tkeep !== keep) begin errors++; $display("FAIL basic_tkeep got %h want %h", out_tkeep, keep); end
        checks++; if (cmd_ready !== 1'b0 || in_tready !== 1'b0) begin errors++; $display("FAIL basic_send_ready got %b/%b want 0/0", cmd_ready, in_tready); end
        handshake(0);
        checks++; if (out_tvalid !== 1'b0 || in_tready !== 1'b1) begin errors++; $display("FAIL basic_wait_entry got tvalid %b tready %b want 0 1", out_tvalid, in_tready); end
        beat_data[0] = exp_d;
        beat_keep[0] = keep;
        send_beats(1, taken);
        pass_exp++;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_rsp_valid got %b want 1", rsp_valid); end
        checks++; if (rsp_match !== 1'b1 || rsp_timeout !== 1'b0) begin errors++; $display("FAIL basic_rsp_flags got m%b t%b want m1 t0", rsp_match, rsp_timeout); end
        checks++; if (rsp_data !== exp_d || rsp_data[511:504] !== 8'h04) begin errors++; $display("FAIL basic_rsp_data got %h want %h", rsp_data, exp_d); end
        checks++; if (rsp_keep !== keep) begin errors++; $display("FAIL basic_rsp_keep got %h want %h", rsp_keep, keep); end
        checks++; if (pass_count !== 16'(pass_exp) || fail_count !== 16'(fail_exp)) begin errors++; $display("FAIL basic_counts got %0d/%0d want %0d/%0d", pass_count, fail_count, pass_exp, fail_exp); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL basic_done_cmd_ready got %b want 0", cmd_ready); end
        tick();
        checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL basic_after_done got valid %b ready %b want 0 1", rsp_valid, cmd_ready); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] reqs [2];
        logic [DW-1:0] one;
        int acc [2];
        int taken;
        reqs[0] = DW'(8'h01);
        reqs[1] = DW'(8'h7F);
        for (int i = 0; i < 2; i++) begin
            issue_cmd(reqs[i], '1, acc[i]);
            handshake(0);
            beat_data[0] = model_double(reqs[i]);
            beat_keep[0] = '1;
            send_beats(1, taken);
            pass_exp++;
            checks++; if (rsp_valid !== 1'b1 || rsp_match !== 1'b1 || rsp_data !== model_double(reqs[i])) begin errors++; $display("FAIL b2b_rsp%0d got v%b m%b %h want v1 m1 %h", i, rsp_valid, rsp_match, rsp_data, model_double(reqs[i])); end
            tick();
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse%0d got %b want 0", i, rsp_valid); end
        end
        checks++; if (acc[1] - acc[0] != 4) begin errors++; $display("FAIL b2b_cmd_spacing got %0d want 4", acc[1] - acc[0]); end
        checks++; if (pass_count !== 16'(pass_exp) || fail_count !== 16'(fail_exp)) begin errors++; $display("FAIL b2b_counts got %0d/%0d want %0d/%0d", pass_count, fail_count, pass_exp, fail_exp); end

        // Randomized exchanges: random data, stalls, reply delays and corruption.
        one = DW'(1);
        for (int i = 0; i < 8; i++) begin
            logic [DW-1:0] req, exp_d;
            logic [KW-1:0] keep;
            logic match_exp;
            int waited;
            req   = rand_word();
            keep  = {$urandom, $urandom};
            exp_d = model_double(req);
            beat_data[0] = ($urandom_range(0, 2) == 0) ? (exp_d ^ (one << $urandom_range(0, DW - 1))) : exp_d;
            beat_keep[0] = {$urandom, $urandom};
            match_exp = (beat_data[0] == exp_d);
            drive_exchange(req, keep, $urandom_range(0, 4), $urandom_range(0, TMO - 2), 1, taken, waited);
            if (match_exp) pass_exp++; else fail_exp++;
            checks++; if (rsp_valid !== 1'b1 || waited != 0) begin errors++; $display("FAIL rand%0d_rsp_valid got %b after %0d want 1 after 0", i, rsp_valid, waited); end
            checks++; if (rsp_match !== match_exp || rsp_data !== beat_data[0] || rsp_keep !== beat_keep[0]) begin errors++; $display("FAIL rand%0d_record got m%b %h want m%b %h", i, rsp_match, rsp_data, match_exp, beat_data[0]); end
            checks++; if (pass_count !== 16'(pass_exp) || fail_count !== 16'(fail_exp)) begin errors++; $display("FAIL rand%0d_counts got %0d/%0d want %0d/%0d", i, pass_count, fail_count, pass_exp, fail_exp); end
            tick();
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] req;
        int taken, waited;
        req = '0;
        req[DW-1] = 1'b1;
        req[0]    = 1'b1;
        beat_data[0] = model_double(req);
        beat_keep[0] = '1;
        drive_exchange(req, '1, 0, 0, 1, taken, waited);
        pass_exp++;
        checks++; if (rsp_valid !== 1'b1 || rsp_match !== 1'b1 || rsp_data !== DW'(2)) begin errors++; $display("FAIL wrap_rsp got v%b m%b %h want v1 m1 2", rsp_valid, rsp_match, rsp_data); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] req;
        logic [KW-1:0] keep;
        int acc, taken;
        req  = rand_word();
        keep = {$urandom, $urandom};
        issue_cmd(req, keep, acc);
        // The reply is presented early; it must stall until WAIT.
        in_tvalid = 1'b1;
        in_tdata  = model_double(req);
        in_tkeep  = keep;
        in_tlast  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++; if (out_tvalid !== 1'b1 || out_tdata !== req || out_tkeep !== keep || in_tready !== 1'b0) begin errors++; $display("FAIL bp_stall%0d got v%b tready %b data_ok %b", i, out_tvalid, in_tready, out_tdata === req); end
            tick();
        end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_early_rsp got %b want 0", rsp_valid); end
        handshake(0);
        checks++; if (in_tready !== 1'b1) begin errors++; $display("FAIL bp_wait_ready got %b want 1", in_tready); end
        tick();
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        pass_exp++;
        checks++; if (rsp_valid !== 1'b1 || rsp_match !== 1'b1 || rsp_data !== model_double(req)) begin errors++; $display("FAIL bp_rsp got v%b m%b want v1 m1", rsp_valid, rsp_match); end
        tick();
    endtask

    task automatic test_timeout();
        logic [DW-1:0] req;
        int acc, waited, taken;
        // Silent responder.
        req = rand_word();
        issue_cmd(req, '1, acc);
        handshake(0);
        wait_rsp(waited);
        fail_exp++;
        checks++; if (rsp_valid !== 1'b1 || waited != TMO) begin errors++; $display("FAIL tmo_latency got v%b after %0d want v1 after %0d", rsp_valid, waited, TMO); end
        checks++; if (rsp_timeout !== 1'b1 || rsp_match !== 1'b0 || rsp_data !== '0) begin errors++; $display("FAIL tmo_record got t%b m%b data_zero %b want t1 m0 1", rsp_timeout, rsp_match, rsp_data === '0); end
        checks++; if (fail_count !== 16'(fail_exp) || pass_count !== 16'(pass_exp)) begin errors++; $display("FAIL tmo_counts got %0d/%0d want %0d/%0d", pass_count, fail_count, pass_exp, fail_exp); end
        tick();
        // Beat arrives in the last WAIT cycle.
        req = rand_word();
        issue_cmd(req, '1, acc);
        handshake(0);
        repeat (TMO - 1) tick();
        checks++; if (rsp_valid !== 1'b0 || in_tready !== 1'b1) begin errors++; $display("FAIL tmo_last_wait got v%b tready %b want v0 tready 1", rsp_valid, in_tready); end
        beat_data[0] = model_double(req);
        beat_keep[0] = '1;
        send_beats(1, taken);
        pass_exp++;
        checks++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_match !== 1'b1) begin errors++; $display("FAIL tmo_late_beat got v%b t%b m%b want v1 t0 m1", rsp_valid, rsp_timeout, rsp_match); end
        tick();
    endtask

    task automatic test_multi_beat();
        logic [DW-1:0] req;
        int taken, waited;
        req = rand_word();
        beat_data[0] = model_double(req);
        beat_data[1] = rand_word();
        beat_data[2] = rand_word();
        for (int i = 0; i < 3; i++) beat_keep[i] = {$urandom, $urandom};
        drive_exchange(req, '1, 1, 1, 3, taken, waited);
        fail_exp++;
        checks++; if (taken != 3) begin errors++; $display("FAIL multi_taken got %0d want 3", taken); end
        checks++; if (rsp_valid !== 1'b1 || waited != 0 || rsp_match !== 1'b0 || rsp_timeout !== 1'b0) begin errors++; $display("FAIL multi_rsp got v%b w%0d m%b t%b want v1 w0 m0 t0", rsp_valid, waited, rsp_match, rsp_timeout); end
        checks++; if (rsp_data !== beat_data[0] || rsp_keep !== beat_keep[0]) begin errors++; $display("FAIL multi_first_beat got %h want %h", rsp_data, beat_data[0]); end
        checks++; if (fail_count !== 16'(fail_exp) || pass_count !== 16'(pass_exp)) begin errors++; $display("FAIL multi_counts got %0d/%0d want %0d/%0d", pass_count, fail_count, pass_exp, fail_exp); end
        tick();
        checks++; if (in_tready !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL multi_idle got tready %b ready %b want 0 1", in_tready, cmd_ready); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] req;
        int acc, taken, waited;
        req = rand_word();
        issue_cmd(req, '1, acc);
        checks++; if (out_tvalid !== 1'b1) begin errors++; $display("FAIL rstmid_send got %b want 1", out_tvalid); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pass_exp = 0;
        fail_exp = 0;
        checks++; if (out_tvalid !== 1'b0 || cmd_ready !== 1'b1 || in_tready !== 1'b0) begin errors++; $display("FAIL rstmid_state got v%b ready %b tready %b want 0 1 0", out_tvalid, cmd_ready, in_tready); end
        checks++; if (pass_count !== 16'd0 || fail_count !== 16'd0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_counts got %0d/%0d v%b want 0/0 v0", pass_count, fail_count, rsp_valid); end
        req = rand_word();
        beat_data[0] = model_double(req);
        beat_keep[0] = '1;
        drive_exchange(req, '1, 0, 0, 1, taken, waited);
        pass_exp++;
        checks++; if (rsp_valid !== 1'b1 || rsp_match !== 1'b1 || pass_count !== 16'(pass_exp) || fail_count !== 16'(fail_exp)) begin errors++; $display("FAIL rstmid_recover got v%b m%b %0d/%0d want v1 m1 %0d/%0d", rsp_valid, rsp_match, pass_count, fail_count, pass_exp, fail_exp); end
        tick();
    endtask

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_data   = '0;
        cmd_keep   = '0;
        out_tready = 1'b0;
        in_tvalid  = 1'b0;
        in_tdata   = '0;
        in_tkeep   = '0;
        in_tlast   = 1'b0;
        tick();
        test_reset();
        test_basic_pass();
        test_back_to_back();
        test_wrap();
        test_backpressure();
        test_timeout();
        test_multi_beat();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xvc_stream_initiator.md
# xvc_stream_initiator

Initiator side of the single-beat AXI-Stream request/response exchange terminated by `test_hardware_server`. It accepts a request word from a command port and transmits it as a one-beat packet on its output stream, which drives the server's input. It then waits for the server's reply beat on its input stream and checks it against the expected value: the request doubled, modulo 2^DATA_WIDTH. Each exchange yields one result record (response data, match flag, timeout flag) plus saturating pass/fail counters, for bring-up of the XVC data path without a host.

## Interface
- `DATA_WIDTH`, 512: TDATA width of both streams and the command word; a multiple of 8.
- `TIMEOUT_CYCLES`, 1024: number of WAIT cycles without a response beat before the exchange is abandoned; ≥ 2.

Ports:
- `i_clk`  in  1  single clock; everything is on its rising edge.
- `i_reset`  in  1  reset, synchronous and active-high.
- `i_cmd_valid`  in  1  request word valid.
- `o_cmd_ready`  out  1  request accepted when high together with `i_cmd_valid`.
- `i_cmd_data`  in  DATA_WIDTH  request word.
- `i_cmd_keep`  in  DATA_WIDTH/8  byte enables for the request.
- `o_output_TVALID`  out  1  request beat valid (to server input).
- `i_output_TREADY`  in  1  server ready for the request beat.
- `o_output_TDATA`  out  DATA_WIDTH  request beat data.
- `o_output_TKEEP`  out  DATA_WIDTH/8  request beat byte enables.
- `o_output_TLAST`  out  1  always 1 while TVALID is high.
- `i_input_TVALID`  in  1  response beat valid (from server output).
- `o_input_TREADY`  out  1  initiator ready for a response beat.
- `i_input_TDATA`  in  DATA_WIDTH  response data.
- `i_input_TKEEP`  in  DATA_WIDTH/8  response byte enables; captured, not checked.
- `i_input_TLAST`  in  1  response end of packet.
- `o_rsp_valid`  out  1  one-cycle pulse: a result record is valid.
- `o_rsp_data`  out  DATA_WIDTH  first response beat data; 0 on timeout.
- `o_rsp_keep`  out  DATA_WIDTH/8  first response beat TKEEP.
- `o_rsp_match`  out  1  response was a single beat and equalled the expected value.
- `o_rsp_timeout`  out  1  no response beat arrived within TIMEOUT_CYCLES.
- `o_pass_count`  out  16  saturating count of matched exchanges.
- `o_fail_count`  out  16  saturating count of mismatched and timed-out exchanges.

## Operation
The controller is a state machine with states IDLE, SEND, WAIT, DRAIN and DONE.
- **IDLE**: `o_cmd_ready`=1. When `i_cmd_valid` is high, latch data and keep, compute expected = (i_cmd_data << 1) truncated to DATA_WIDTH, and go to SEND.
- **SEND**: `o_output_TVALID`=1 with the latched data and keep and TLAST=1. Data, keep and last hold stable until `i_output_TREADY`. On that handshake, clear the timeout counter and go to WAIT.
- **WAIT**: `o_input_TREADY`=1. On a beat, capture TDATA/TKEEP and set match = (TDATA == expected).
  - If TLAST=1, go to DONE.
  - If TLAST=0, force match=0 and go to DRAIN.
  - With no beat, increment the counter. When the counter equals TIMEOUT_CYCLES-1, set timeout=1 and match=0, force data=0, and go to DONE.
- **DRAIN**: `o_input_TREADY`=1. Discard beats until one with TLAST=1, then go to DONE. DRAIN has no timeout.
- **DONE**: `o_rsp_valid`=1 for exactly one cycle with the record. Increment `o_pass_count` if match, otherwise `o_fail_count`; both saturate at 16'hFFFF. Then go to IDLE.

General rules:
- `o_cmd_ready` is 0 outside IDLE. `o_input_TREADY` is 0 outside WAIT and DRAIN, so early or stray response beats stall at the server and are never dropped.
- Record outputs hold their last values between pulses.

## Timing
- All outputs are registered. Reset values: every output is 0 except that `o_cmd_ready` is 1 in the first cycle after reset.
- Command accepted on edge N → `o_output_TVALID` high from cycle N+1.
- Output handshake on edge S → TVALID is low and `o_input_TREADY` is high in cycle S+1.
- Response TLAST beat accepted on edge R → `o_rsp_valid` and updated counters in cycle R+1 → `o_cmd_ready` high in cycle R+2.
- Timeout: with WAIT entered in cycle S+1 and no beat arriving, `o_rsp_valid` pulses in cycle S+1+TIMEOUT_CYCLES.
- A beat that arrives in the final WAIT cycle takes priority over the timeout.
- Minimum exchange, with an immediate TREADY and a response in the first WAIT cycle: command to command is 4 cycles.
- Reset asserted mid-exchange:
  - The next cycle is IDLE with all outputs at reset values; an in-flight TVALID is dropped.
  - Counters clear to 0.
  - Any late response from the abandoned exchange stalls until the next WAIT, where it is checked against the new request. The bench must reset the server alongside this block.

## Test plan
- **Basic pass**: request 0x02…00863787d9…0, keep 64'h8000000000000000, echo loopback that doubles it → `o_rsp_match`=1, `o_rsp_data`=0x04…010c6f0fb2…0, pass=1, fail=0, output TLAST=1.
- **Back-to-back**: requests 0x01 then 0x7F with a doubling responder → matches with data 0x02 and 0xFE, pass=2, and each `o_rsp_valid` is a single-cycle pulse.
- **Wrap**: request with MSB set (1<<511 | 1) → expected 0x2; responder returns 0x2 → match=1.
- **Backpressure**: hold `i_output_TREADY` low for 10 cycles → TVALID, TDATA and TKEEP stay stable; the response is only accepted after the handshake.
- **Timeout**: TIMEOUT_CYCLES=8 with a silent responder → `o_rsp_valid` 8 cycles after WAIT entry with timeout=1, match=0, data=0, fail=1. A second run with the beat arriving in WAIT cycle 8 → timeout=0.
- **Multi-beat and reset**: a 3-beat response (TLAST on the third beat) → match=0 and all 3 beats consumed. Reset asserted while in SEND → TVALID=0 and `o_cmd_ready`=1 in the next cycle, with counters at 0.
